// File: rtl/lenet_frame_sequencer.sv
// Frame sequencer for the Lenet core: packs a pixel stream into CNNinput, runs the core for a
// fixed window, then offers the class on a valid/ready port. Optional macro: LENET_PREFETCH_EN.
module lenet_frame_sequencer #(
  parameter int unsigned PIX_W      = 16,
  parameter int unsigned IMG_DIM    = 32,
  parameter int unsigned RUN_CYCLES = 75720,
  parameter int unsigned CNT_W      = 17,
  parameter int unsigned CLASS_W    = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             pix_valid_i,
  input  logic [PIX_W-1:0]                 pix_data_i,
  input  logic                             pix_last_i,
  output logic                             pix_ready_o,
  output logic                             lenet_reset_o,
  output logic [IMG_DIM*IMG_DIM*PIX_W-1:0] lenet_image_o,
  input  logic [CLASS_W-1:0]               lenet_class_i,
  output logic                             res_valid_o,
  output logic [CLASS_W-1:0]               res_class_o,
  input  logic                             res_ready_i,
  output logic                             frame_err_o,
  output logic                             busy_o,
  output logic [15:0]                      frame_cnt_o
);

  localparam int unsigned NumPix  = IMG_DIM * IMG_DIM;
  localparam int unsigned ImgW    = NumPix * PIX_W;
  localparam int unsigned PixCntW = (NumPix > 1) ? $clog2(NumPix) : 1;
  localparam logic [PixCntW-1:0] LastIdx = PixCntW'(NumPix - 1);
  localparam logic [CNT_W-1:0]   RunLast = CNT_W'(RUN_CYCLES - 1);

  typedef enum logic [1:0] {StLoad, StRun, StResult} state_e;

  state_e               state_q, state_d;
  logic [PixCntW-1:0]   pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0]     run_cnt_q, run_cnt_d;
  logic [ImgW-1:0]      image_q, image_d;
  logic [CLASS_W-1:0]   res_class_q, res_class_d;
  logic                 frame_err_q, frame_err_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;

  logic                 pix_hs, at_last, frame_ok, frame_bad;
  logic [ImgW-1:0]      packed_img;

`ifdef LENET_PREFETCH_EN
  logic [ImgW-1:0]      shadow_q, shadow_d;
  logic                 shadow_full_q, shadow_full_d;

  assign pix_ready_o = !shadow_full_q;
  assign packed_img  = {shadow_q[ImgW-PIX_W-1:0], pix_data_i};
`else
  assign pix_ready_o = (state_q == StLoad);
  assign packed_img  = {image_q[ImgW-PIX_W-1:0], pix_data_i};
`endif

  assign pix_hs    = pix_valid_i && pix_ready_o;
  assign at_last   = (pix_cnt_q == LastIdx);
  assign frame_ok  = pix_hs && at_last && pix_last_i;
  assign frame_bad = pix_hs && (at_last != pix_last_i);

  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    run_cnt_d   = run_cnt_q;
    image_d     = image_q;
    res_class_d = res_class_q;
    frame_cnt_d = frame_cnt_q;
    frame_err_d = frame_bad;
`ifdef LENET_PREFETCH_EN
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
`endif

    // Either a good or a bad frame end restarts the pixel count.
    if (pix_hs) begin
      pix_cnt_d = (at_last || pix_last_i) ? '0 : pix_cnt_q + PixCntW'(1);
    end

`ifdef LENET_PREFETCH_EN
    if (pix_hs) shadow_d = packed_img;
    if (frame_ok) shadow_full_d = 1'b1;
`else
    if (pix_hs) image_d = packed_img;
`endif

    unique case (state_q)
      StLoad: begin
`ifdef LENET_PREFETCH_EN
        if (shadow_full_q) begin
          image_d       = shadow_q;
          shadow_full_d = 1'b0;
          run_cnt_d     = '0;
          state_d       = StRun;
        end
`else
        if (frame_ok) begin
          run_cnt_d = '0;
          state_d   = StRun;
        end
`endif
      end
      StRun: begin
        run_cnt_d = run_cnt_q + CNT_W'(1);
        if (run_cnt_q == RunLast) begin
          res_class_d = lenet_class_i;
          state_d     = StResult;
        end
      end
      StResult: begin
        if (res_ready_i) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = StLoad;
`ifndef LENET_PREFETCH_EN
          pix_cnt_d   = '0;
`endif
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StLoad;
      pix_cnt_q   <= '0;
      run_cnt_q   <= '0;
      image_q     <= '0;
      res_class_q <= '0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      run_cnt_q   <= run_cnt_d;
      image_q     <= image_d;
      res_class_q <= res_class_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

`ifdef LENET_PREFETCH_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
    end
  end
`endif

  // Reset stays high in LOAD and RESULT, so every run is preceded by a reset pulse.
  assign lenet_reset_o = (state_q != StRun);
  assign lenet_image_o = image_q;
  assign res_valid_o   = (state_q == StResult);
  assign res_class_o   = res_class_q;
  assign frame_err_o   = frame_err_q;
  assign busy_o        = (state_q != StLoad);
  assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_lenet_frame_sequencer.sv
// Scoreboard bench for lenet_frame_sequencer with a shortened run window.
module tb_lenet_frame_sequencer;

  localparam int RUN = 300;

  logic             clk = 1'b0;
  logic             rst;
  logic             pix_valid, pix_last, pix_ready;
  logic [15:0]      pix_data;
  logic             lenet_reset;
  logic [16383:0]   lenet_image;
  logic [3:0]       lenet_class, res_class, cls_tgt;
  logic             res_valid, rr, frame_err, busy;
  logic [15:0]      frame_cnt;

  int total = 0, bad = 0;
  int hs_cnt = 0, exp_fc = 0, runs = 0, low_run = 0;
  int err_pulses = 0, err_cycles = 0;
  logic err_prev = 1'b0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  lenet_frame_sequencer #(
    .PIX_W(16), .IMG_DIM(32), .RUN_CYCLES(RUN), .CNT_W(17), .CLASS_W(4)
  ) dut (
    .clk_i(clk), .reset_i(rst),
    .pix_valid_i(pix_valid), .pix_data_i(pix_data), .pix_last_i(pix_last),
    .pix_ready_o(pix_ready), .lenet_reset_o(lenet_reset), .lenet_image_o(lenet_image),
    .lenet_class_i(lenet_class), .res_valid_o(res_valid), .res_class_o(res_class),
    .res_ready_i(rr), .frame_err_o(frame_err), .busy_o(busy), .frame_cnt_o(frame_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Core model: drives the target class only in the last run cycle, checks run length.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      low_run = 0;
      lenet_class = ~cls_tgt;
    end else if (!lenet_reset) begin
      if (low_run == 0) runs++;
      low_run++;
      lenet_class = (low_run == RUN) ? cls_tgt : ~cls_tgt;
    end else begin
      if (low_run != 0) begin
        chk("run_len", low_run, RUN);
        chk("res_valid_after_run", {31'd0, res_valid}, 1);
      end
      low_run = 0;
      lenet_class = ~cls_tgt;
    end
  end

  always @(negedge clk) begin
    #1;
    if (frame_err) begin
      err_cycles++;
      if (!err_prev) err_pulses++;
    end
    err_prev = frame_err;
  end

  // Result monitor
  always @(negedge clk) begin
    #1;
    if (!rst && res_valid && rr) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", {31'd0, res_valid}, 0);
      end else begin
        chk("res_class", {28'd0, res_class}, {28'd0, exp_q.pop_front()});
        chk("frame_cnt_at_hs", {16'd0, frame_cnt}, exp_fc);
      end
      exp_fc++;
      hs_cnt++;
    end
  end

  task automatic send_pix(input logic [15:0] d, input logic l);
    int t = 0;
    pix_valid = 1'b1; pix_data = d; pix_last = l;
    while (!pix_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) chk("pix_ready_timeout", {31'd0, pix_ready}, 1);
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input int last_at, input logic [15:0] base);
    for (int k = 0; k < n; k++) send_pix(base + 16'(k), k == last_at);
  endtask

  task automatic wait_hs(input int target);
    int t = 0;
    while (hs_cnt < target && t < 4000) begin
      @(negedge clk);
      t++;
    end
    chk("result_hs_seen", {31'd0, hs_cnt >= target}, 1);
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!res_valid && t < 4000) begin
      @(negedge clk);
      t++;
    end
    chk("res_valid_seen", {31'd0, res_valid}, 1);
  endtask

  initial begin
    rst = 1'b1; pix_valid = 1'b0; pix_data = '0; pix_last = 1'b0; rr = 1'b1; cls_tgt = '0;
    repeat (3) @(negedge clk);
    chk("rst_lenet_reset", {31'd0, lenet_reset}, 1);
    chk("rst_res_valid", {31'd0, res_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 0);
    chk("rst_frame_err", {31'd0, frame_err}, 0);
    chk("rst_pix_ready", {31'd0, pix_ready}, 1);
    chk("rst_res_class", {28'd0, res_class}, 0);
    chk("rst_image_zero", {31'd0, |lenet_image}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Ramp frame, class 6
    cls_tgt = 4'd6; exp_q.push_back(4'd6);
    send_frame(1024, 1023, 16'h0000);
`ifdef LENET_PREFETCH_EN
    @(negedge clk);
`endif
    chk("t1_img_first", {16'd0, lenet_image[16383:16368]}, 32'h0000);
    chk("t1_img_last", {16'd0, lenet_image[15:0]}, 32'h03FF);
    chk("t1_img_mid", {16'd0, lenet_image[(1023-500)*16 +: 16]}, 500);
    chk("t1_busy", {31'd0, busy}, 1);
    chk("t1_lenet_reset_low", {31'd0, lenet_reset}, 0);
    chk("t1_pix_ready_run", {31'd0, pix_ready}, 0);
    wait_hs(1);
    @(negedge clk);
    chk("t1_frame_cnt", {16'd0, frame_cnt}, 1);
    chk("t1_res_valid_drop", {31'd0, res_valid}, 0);
    chk("t1_pix_ready_back", {31'd0, pix_ready}, 1);

    // Back-pressured result, class 9
    rr = 1'b0; cls_tgt = 4'd9; exp_q.push_back(4'd9);
    send_frame(1024, 1023, 16'h1000);
    wait_valid();
    repeat (50) begin
      @(negedge clk);
      chk("t2_res_valid_hold", {31'd0, res_valid}, 1);
      chk("t2_res_class_hold", {28'd0, res_class}, 9);
      chk("t2_lenet_reset_hi", {31'd0, lenet_reset}, 1);
`ifndef LENET_PREFETCH_EN
      chk("t2_pix_ready_lo", {31'd0, pix_ready}, 0);
`endif
    end
    rr = 1'b1;
    @(negedge clk);
    chk("t2_hs_count", hs_cnt, 2);
    chk("t2_res_valid_drop", {31'd0, res_valid}, 0);
    chk("t2_pix_ready_back", {31'd0, pix_ready}, 1);
    chk("t2_frame_cnt", {16'd0, frame_cnt}, 2);

    // Early pix_last on index 500
    send_frame(501, 500, 16'h2000);
    repeat (3) @(negedge clk);
    chk("t3_err_pulses", err_pulses, 1);
    chk("t3_err_cycles", err_cycles, 1);
    chk("t3_lenet_reset_hi", {31'd0, lenet_reset}, 1);
    chk("t3_busy", {31'd0, busy}, 0);
    cls_tgt = 4'd3; exp_q.push_back(4'd3);
    send_frame(1024, 1023, 16'h3000);
`ifdef LENET_PREFETCH_EN
    @(negedge clk);
`endif
    chk("t3_img_first", {16'd0, lenet_image[16383:16368]}, 32'h3000);
    chk("t3_img_last", {16'd0, lenet_image[15:0]}, 32'h33FF);
    wait_hs(3);
    @(negedge clk);
    chk("t3_frame_cnt", {16'd0, frame_cnt}, 3);

    // Missing pix_last on index 1023
    send_frame(1024, -1, 16'h4000);
    repeat (3) @(negedge clk);
    chk("t4_err_pulses", err_pulses, 2);
    chk("t4_err_cycles", err_cycles, 2);
    chk("t4_busy", {31'd0, busy}, 0);
    cls_tgt = 4'd12; exp_q.push_back(4'd12);
    send_frame(1024, 1023, 16'h5000);
`ifdef LENET_PREFETCH_EN
    @(negedge clk);
`endif
    chk("t4_img_first", {16'd0, lenet_image[16383:16368]}, 32'h5000);
    chk("t4_img_last", {16'd0, lenet_image[15:0]}, 32'h53FF);
    wait_hs(4);

    // Asynchronous reset mid-run
    cls_tgt = 4'd5; exp_q.push_back(4'd5);
    send_frame(1024, 1023, 16'h6000);
    repeat (100) @(negedge clk);
    chk("t5_busy_before", {31'd0, busy}, 1);
    rst = 1'b1;
    #1;
    chk("t5_lenet_reset", {31'd0, lenet_reset}, 1);
    chk("t5_res_valid", {31'd0, res_valid}, 0);
    chk("t5_busy", {31'd0, busy}, 0);
    chk("t5_frame_cnt", {16'd0, frame_cnt}, 0);
    exp_q.delete();
    exp_fc = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cls_tgt = 4'd7; exp_q.push_back(4'd7);
    send_frame(1024, 1023, 16'h7000);
    wait_hs(5);
    @(negedge clk);
    chk("t5_frame_cnt_after", {16'd0, frame_cnt}, 1);
    chk("runs_started", runs, 6);

`ifdef LENET_PREFETCH_EN
    // Stream frame B while frame A runs and its result is held
    rr = 1'b0; cls_tgt = 4'd2; exp_q.push_back(4'd2);
    send_frame(1024, 1023, 16'h8000);
    begin
      int t = 0;
      while (lenet_reset && t < 100) begin
        @(negedge clk);
        t++;
      end
    end
    chk("t6_a_running", {31'd0, lenet_reset}, 0);
    send_frame(1024, 1023, 16'h9000);
    chk("t6_pix_ready_full", {31'd0, pix_ready}, 0);
    wait_valid();
    cls_tgt = 4'd4; exp_q.push_back(4'd4);
    rr = 1'b1;
    @(negedge clk);
    chk("t6_reset_h1", {31'd0, lenet_reset}, 1);
    @(negedge clk);
    chk("t6_reset_h2", {31'd0, lenet_reset}, 0);
    chk("t6_img_first", {16'd0, lenet_image[16383:16368]}, 32'h9000);
    chk("t6_img_last", {16'd0, lenet_image[15:0]}, 32'h93FF);
    wait_hs(7);
    chk("t6_runs", runs, 8);
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lenet_frame_sequencer.md
Name: lenet_frame_sequencer

Overview:
- Sequences the Lenet core one image at a time: assembles a 32x32 frame of 16-bit pixels from a valid/ready stream into the Lenet CNNinput vector, and holds Lenet in reset while loading.
- Releases reset for a fixed run window, then samples LeNetoutput and presents it on a valid/ready result port.
- Replaces bench-level reset/wait sequencing so Lenet can run continuously on hardware.

Parameters:
- PIX_W, 16, pixel width (half-float bits).
- IMG_DIM, 32, frame edge; frame holds IMG_DIM*IMG_DIM pixels.
- RUN_CYCLES, 75720, cycles Lenet is held out of reset per frame (75050+20+550+100).
- CNT_W, 17, width of the run counter; must hold RUN_CYCLES.
- CLASS_W, 4, class index width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- pix_valid  in  1  pixel strobe.
- pix_data  in  PIX_W  pixel value, raster order.
- pix_last  in  1  marks the final pixel of a frame.
- pix_ready  out  1  pixel accept.
- lenet_reset  out  1  drives Lenet reset; 1 holds the core in reset.
- lenet_image  out  IMG_DIM*IMG_DIM*PIX_W  drives Lenet CNNinput.
- lenet_class  in  CLASS_W  Lenet LeNetoutput.
- res_valid  out  1  result available.
- res_class  out  CLASS_W  captured class.
- res_ready  in  1  result accept.
- frame_err  out  1  one-cycle pulse on a framing error.
- busy  out  1  high in RUN or RESULT.
- frame_cnt  out  16  completed results handed off; wraps 0xFFFF->0.

Behaviour:
- Reset values (async):
  - state=LOAD, pixel count=0, run count=0.
  - lenet_reset=1, lenet_image=0.
  - res_valid=0, res_class=0, frame_err=0, busy=0, frame_cnt=0.
  - pix_ready=1 combinationally in LOAD.
- Pixel packing: each accepted pixel shifts the image register left by PIX_W and is inserted at [PIX_W-1:0]. After a full frame, the first pixel sits at the MSBs and the last at the LSBs, which matches the hex-string order.
- States:
  - LOAD:
    - pix_ready=1, lenet_reset=1.
    - Each handshake increments the pixel count.
    - On the handshake of pixel index N-1 (N=IMG_DIM^2) with pix_last=1: go to RUN, clear run count.
  - RUN:
    - pix_ready=0, lenet_reset=0, lenet_image is held stable.
    - Run count increments every cycle.
    - At count RUN_CYCLES-1: capture lenet_class into res_class and go to RESULT.
  - RESULT:
    - res_valid=1, lenet_reset=1, pix_ready=0.
    - res_class is held stable while res_ready=0.
    - On res_valid&&res_ready: increment frame_cnt, go to LOAD, clear pixel count.
- Latency: if the last pixel handshakes in cycle T:
  - lenet_reset=0 exactly in cycles T+1..T+RUN_CYCLES.
  - res_class = lenet_class sampled in cycle T+RUN_CYCLES.
  - res_valid rises in T+RUN_CYCLES+1.
- Framing errors:
  - pix_last=1 on index < N-1, or pix_last=0 on index N-1: pulse frame_err for 1 cycle, discard the frame, clear the pixel count, stay in LOAD.
  - lenet_reset never drops for a discarded frame.
  - The image register keeps its partial contents, which is harmless.
- pix_valid outside LOAD is ignored (pix_ready=0).
- Async reset mid-RUN or mid-RESULT aborts immediately; a pending result is lost and frame_cnt clears.
- Between consecutive runs, lenet_reset stays high for at least 1 cycle, which guarantees a reset pulse to Lenet.

Optional Feature:
- LENET_PREFETCH_EN defined:
  - Adds a shadow frame buffer plus a shadow-full flag.
  - Pixels always load into the shadow, with the same packing and framing rules.
  - pix_ready = !shadow_full in every state.
  - When in LOAD with shadow_full: copy shadow to lenet_image, clear shadow_full, enter RUN the next cycle.
  - Result: a result handshake in cycle H, with the shadow already full, gives RUN starting at H+2.
  - Streaming may overlap RUN and RESULT.
- Undefined: single buffer exactly as above; no pixels are accepted outside LOAD.

Test Plan:
1. Frame with pixel k = k (0x0000..0x03FF), pix_last on k=1023, lenet_class=6 -> lenet_image[16383:16368]=0x0000, [15:0]=0x03FF; lenet_reset low exactly 75720 cycles; res_valid with res_class=6; frame_cnt=1.
2. Same frame, res_ready held low 50 cycles after res_valid -> res_valid and res_class=6 stable; lenet_reset=1, pix_ready=0 (macro off); handshake, then pix_ready=1 next cycle.
3. pix_last asserted on pixel 500 -> frame_err one 1-cycle pulse; lenet_reset stays 1; following valid 1024-pixel frame runs normally; frame_cnt=1.
4. 1024th pixel with pix_last=0 -> frame_err pulse, no RUN; next 1024-pixel frame accepted from count 0.
5. Assert reset at run count 1000 -> same cycle: lenet_reset=1, res_valid=0, busy=0, frame_cnt=0; next frame completes normally.
6. LENET_PREFETCH_EN: stream frame B during frame A's RUN -> pix_ready drops after B's 1024th pixel; A result handshake at H; lenet_reset low from H+2 for 75720 cycles with B's image.
